mac_pipe_acc: RTL

- Parametrised, pipelined multiply-accumulate unit that computes windowed dot products of ACC_LEN operand pairs.
- Operand width, accumulator width, window length and signedness are set by parameters.
- Valid/ready handshakes on input and output, with full-pipeline backpressure.
- Sits between an operand streamer and a result sink in the MAC datapath.

---
 rtl/mac_pipe_acc.sv | 88 ++++++++
 1 files changed

// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: two-stage pipelined multiply-accumulate producing windowed dot products of ACC_LEN pairs
// Ports: clk, rst (async, active-low); in_valid/in_ready/a/b operand handshake; clear aborts the
// current window; out_valid/out_ready/result/overflow result handshake; win_cnt = products summed so far.
// Optional MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module mac_pipe_acc #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int ACC_LEN = 16,
    parameter int SIGNED  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           result,
    output logic                       overflow,
    output logic [$clog2(ACC_LEN)-1:0] win_cnt
);
    localparam int PW = 2 * DATA_W;
    localparam int CW = $clog2(ACC_LEN);
    logic                 adv, s1_valid, ovf_sticky, ovf_now, last;
    logic [PW-1:0]        prod, prod_u;
    logic signed [PW-1:0] prod_s;
    logic [ACC_W-1:0]     acc, ext, sum, acc_nx;
    logic [ACC_W:0]       sum_w;
`ifdef MAC_SAT_EN
    logic [ACC_W-1:0]     sat_val;
`endif
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign prod_u   = PW'(a) * PW'(b);
    assign prod_s   = PW'($signed(a)) * PW'($signed(b));
    always_comb begin
        ext     = (SIGNED != 0) ? ACC_W'($signed(prod)) : ACC_W'(prod);
        sum_w   = {1'b0, acc} + {1'b0, ext};
        sum     = sum_w[ACC_W-1:0];
        // signed overflow: operands share a sign that the sum does not
        ovf_now = (SIGNED != 0) ? (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])
                                : sum_w[ACC_W];
        last    = win_cnt == CW'(ACC_LEN - 1);
`ifdef MAC_SAT_EN
        // overflow direction follows the accumulator sign; unsigned can only overflow upward
        sat_val = (SIGNED != 0) ? {acc[ACC_W-1], {(ACC_W-1){~acc[ACC_W-1]}}} : '1;
        acc_nx  = ovf_sticky ? acc : (ovf_now ? sat_val : sum);
`else
        acc_nx  = sum;
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            prod       <= '0;
            acc        <= '0;
            win_cnt    <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid & ~clear;
            prod     <= (SIGNED != 0) ? prod_s : prod_u;
            if (clear) begin
                acc        <= '0;
                win_cnt    <= '0;
                ovf_sticky <= 1'b0;
            end else if (s1_valid) begin
                if (last) begin
                    result     <= acc_nx;
                    overflow   <= ovf_sticky | ovf_now;
                    acc        <= '0;
                    win_cnt    <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= acc_nx;
                    win_cnt    <= win_cnt + 1'b1;
                    ovf_sticky <= ovf_sticky | ovf_now;
                end
            end
            // a completion reloads the output; otherwise an advancing stage drains it
            out_valid <= s1_valid & ~clear & last;
        end
    end
endmodule
